// File: rtl/qft_run_controller.sv
// qft_run_controller: sequences one QFT evaluation between the SPI register file
// and the pipelined QFT core.
//   A start request freezes the input registers and issues a one-cycle launch.
//   The controller then waits out the core latency, pulses capture into the
//   output snapshot registers, and raises a sticky done flag.
// Optional build macro: QFT_CTRL_CONTINUOUS_EN adds the cont_mode input. With
//   cont_mode high, CAPTURE goes straight back to LAUNCH.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   start         one-cycle run request (SPI write-decode strobe)
//   abort         one-cycle cancel of the run in flight
//   clear_done    one-cycle clear of done and overrun
//   cfg_latency   runtime latency override; 0 selects PIPE_LATENCY
//   cont_mode     (QFT_CTRL_CONTINUOUS_EN only) keep relaunching after capture
//   in_freeze     high while busy; blocks SPI input-register writes
//   launch        one-cycle valid into the QFT pipeline
//   capture       one-cycle load enable for the output snapshot registers
//   busy          high in any state other than IDLE
//   done          sticky; set the cycle after capture
//   overrun       sticky; a start arrived while busy
//   status        {busy, done, overrun, 1'b0, run_cnt[3:0]}
module qft_run_controller #(
  parameter int unsigned PIPE_LATENCY = 6,
  parameter int unsigned LAT_W        = 4,
  parameter int unsigned RUN_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             clear_done,
  input  logic [LAT_W-1:0] cfg_latency,
`ifdef QFT_CTRL_CONTINUOUS_EN
  input  logic             cont_mode,
`endif
  output logic             in_freeze,
  output logic             launch,
  output logic             capture,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [7:0]       status
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lat_q;
  logic [LAT_W-1:0] cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [LAT_W-1:0] eff_lat;
  logic             cont_go;
  logic             accept;

  // Effective latency; sampled only on entry to LAUNCH.
  assign eff_lat = (cfg_latency == '0) ? LAT_W'(PIPE_LATENCY) : cfg_latency;

`ifdef QFT_CTRL_CONTINUOUS_EN
  assign cont_go = cont_mode;
`else
  assign cont_go = 1'b0;
`endif

  // A start is accepted only from IDLE, and a coincident abort vetoes it.
  assign accept = (state == S_IDLE) && start && !abort;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (accept) state_nxt = S_LAUNCH;
      S_LAUNCH:  begin
        if (abort)                      state_nxt = S_IDLE;
        else if (lat_q == LAT_W'(1))    state_nxt = S_CAPTURE;
        else                            state_nxt = S_WAIT;
      end
      S_WAIT:    begin
        if (abort)                      state_nxt = S_IDLE;
        else if (cnt == LAT_W'(1))      state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = cont_go ? S_LAUNCH : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_q     <= '0;
      cnt       <= '0;
      run_cnt   <= '0;
      launch    <= 1'b0;
      capture   <= 1'b0;
      busy      <= 1'b0;
      in_freeze <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      launch    <= (state_nxt == S_LAUNCH);
      capture   <= (state_nxt == S_CAPTURE);
      busy      <= (state_nxt != S_IDLE);
      in_freeze <= (state_nxt != S_IDLE);

      if (state_nxt == S_LAUNCH) lat_q <= eff_lat;

      if (state == S_LAUNCH)    cnt <= lat_q - LAT_W'(1);
      else if (state == S_WAIT) cnt <= cnt - LAT_W'(1);

      if (state == S_CAPTURE) run_cnt <= run_cnt + RUN_W'(1);

      // Setting done beats a coincident clear.
      if (state == S_CAPTURE)          done <= 1'b1;
      else if (clear_done || accept)   done <= 1'b0;

      // A fresh overrun event is kept even if a clear arrives with it.
      if (start && (state != S_IDLE))  overrun <= 1'b1;
      else if (clear_done)             overrun <= 1'b0;
    end
  end

  assign status = {busy, done, overrun, 1'b0, 4'(run_cnt)};

endmodule

// File: tb/tb_qft_run_controller.sv
// tb_qft_run_controller: table-driven check of qft_run_controller.
// Launch/capture events go through an expected-event queue.
module tb_qft_run_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       clear_done = 1'b0;
  logic [3:0] cfg_latency = 4'd0;
`ifdef QFT_CTRL_CONTINUOUS_EN
  logic       cont_mode = 1'b0;
`endif
  logic       in_freeze, launch, capture, busy, done, overrun;
  logic [7:0] status;

  qft_run_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .clear_done  (clear_done),
    .cfg_latency (cfg_latency),
`ifdef QFT_CTRL_CONTINUOUS_EN
    .cont_mode   (cont_mode),
`endif
    .in_freeze   (in_freeze),
    .launch      (launch),
    .capture     (capture),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .status      (status)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int runs_model = 0;

  typedef struct {
    bit is_cap;
    int cyc;
  } ev_t;
  ev_t evq[$];

  // One scenario: start at cycle 0, optional events at given cycles (-1 = none).
  typedef struct {
    int cfg;
    int start2;
    int abort_at;
    int clear_at;
    int cap;
    int ovr_at;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the expected event whenever the DUT shows a launch or capture pulse.
  task automatic mon(input int c);
    ev_t e;
    if (launch || capture) begin
      if (evq.size() == 0) begin
        chk("unexpected_pulse", {launch, capture}, 32'd0);
      end else begin
        e = evq.pop_front();
        chk("event_cycle", c, e.cyc);
        chk("event_kind", capture, e.is_cap);
      end
    end
  endtask

  // Single run with L=1; bounded wait for the capture pulse.
  task automatic run_one();
    bit seen;
    seen = 1'b0;
    cfg_latency = 4'd1;
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      start = 1'b0;
      if (capture) seen = 1'b1;
      if (seen && !busy) break;
    end
    chk("wrap_run_captured", seen, 1'b1);
    runs_model = (runs_model + 1) % 16;
  endtask

  initial begin : main
    tbl[0] = '{cfg: 0,  start2: -1, abort_at: -1, clear_at: -1, cap: 7,  ovr_at: -1};
    tbl[1] = '{cfg: 1,  start2: -1, abort_at: -1, clear_at: -1, cap: 2,  ovr_at: -1};
    tbl[2] = '{cfg: 3,  start2: -1, abort_at: -1, clear_at: -1, cap: 4,  ovr_at: -1};
    tbl[3] = '{cfg: 0,  start2: 3,  abort_at: -1, clear_at: 10, cap: 7,  ovr_at: 4};
    tbl[4] = '{cfg: 0,  start2: -1, abort_at: 4,  clear_at: -1, cap: -1, ovr_at: -1};
    tbl[5] = '{cfg: 15, start2: -1, abort_at: -1, clear_at: -1, cap: 16, ovr_at: -1};
    tbl[6] = '{cfg: 2,  start2: -1, abort_at: 1,  clear_at: -1, cap: -1, ovr_at: -1};
    tbl[7] = '{cfg: 0,  start2: -1, abort_at: 6,  clear_at: -1, cap: -1, ovr_at: -1};
    tbl[8] = '{cfg: 4,  start2: -1, abort_at: 5,  clear_at: -1, cap: 5,  ovr_at: -1};
    tbl[9] = '{cfg: 2,  start2: 2,  abort_at: -1, clear_at: 3,  cap: 3,  ovr_at: 3};

    // Reset values.
    step();
    chk("reset_status", status, 8'h00);
    chk("reset_pulses", {launch, capture, busy, in_freeze, done, overrun}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_status", status, 8'h00);

    // Table-driven scenarios; cycle 0 is the start cycle.
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      int last;
      v = tbl[i];
      last = (v.cap >= 0) ? v.cap : v.abort_at;
      cfg_latency = 4'(v.cfg);
      start = 1'b1;
      abort = 1'b0;
      clear_done = 1'b0;
      evq.push_back('{is_cap: 1'b0, cyc: 1});
      if (v.cap >= 0) evq.push_back('{is_cap: 1'b1, cyc: v.cap});
      for (int c = 1; c <= 20; c++) begin
        bit busy_e, done_e, ovr_e;
        int rc;
        step();
        mon(c);
        busy_e = (c <= last);
        done_e = (v.cap >= 0) && (c > v.cap) && !((v.clear_at > v.cap) && (c > v.clear_at));
        ovr_e  = (v.ovr_at >= 0) && (c >= v.ovr_at) &&
                 !((v.clear_at >= v.ovr_at) && (c > v.clear_at));
        rc = (runs_model + ((v.cap >= 0 && c > v.cap) ? 1 : 0)) % 16;
        chk($sformatf("v%0d_c%0d_busy", i, c), busy, busy_e);
        chk($sformatf("v%0d_c%0d_freeze", i, c), in_freeze, busy_e);
        chk($sformatf("v%0d_c%0d_status", i, c), status,
            {busy_e, done_e, ovr_e, 1'b0, 4'(rc)});
        // Scramble the override after the start cycle; the run must ignore it.
        cfg_latency = 4'($urandom);
        start       = (c == v.start2);
        abort       = (c == v.abort_at);
        clear_done  = (c == v.clear_at);
      end
      chk($sformatf("v%0d_events_left", i), evq.size(), 0);
      evq.delete();
      if (v.cap >= 0) runs_model = (runs_model + 1) % 16;
      start = 1'b0;
      abort = 1'b0;
      clear_done = 1'b0;
    end

    // start and abort together in IDLE: nothing launched, done left set.
    chk("pre_abort_done", done, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("start_abort_launch", launch, 1'b0);
      chk("start_abort_busy", busy, 1'b0);
      chk("start_abort_done", done, 1'b1);
      step();
    end

    // Run counter wrap back to zero.
    begin
      int n;
      n = 16 - runs_model;
      for (int k = 0; k < n; k++) run_one();
      step();
      chk("wrap_model_zero", runs_model, 0);
      chk("wrap_status_cnt", status[3:0], 4'd0);
      chk("wrap_done", done, 1'b1);
    end

    // Asynchronous reset during WAIT.
    cfg_latency = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_reset_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_status", status, 8'h00);
    chk("async_reset_pulses", {launch, capture, busy, in_freeze, done, overrun}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runs_model = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("post_reset_no_capture", capture, 1'b0);
    end
    chk("post_reset_status", status, 8'h00);

`ifdef QFT_CTRL_CONTINUOUS_EN
    // Streaming with L=2, cont_mode dropped before the third capture.
    cont_mode = 1'b1;
    cfg_latency = 4'd2;
    start = 1'b1;
    evq.push_back('{is_cap: 1'b0, cyc: 1});
    evq.push_back('{is_cap: 1'b1, cyc: 3});
    evq.push_back('{is_cap: 1'b0, cyc: 4});
    evq.push_back('{is_cap: 1'b1, cyc: 6});
    evq.push_back('{is_cap: 1'b0, cyc: 7});
    evq.push_back('{is_cap: 1'b1, cyc: 9});
    for (int c = 1; c <= 14; c++) begin
      step();
      start = 1'b0;
      mon(c);
      chk("cont_busy", busy, (c <= 9));
      chk("cont_freeze", in_freeze, (c <= 9));
      chk("cont_done", done, (c >= 4));
      if (c == 8) cont_mode = 1'b0;
    end
    chk("cont_events_left", evq.size(), 0);
    chk("cont_run_cnt", status[3:0], 4'd3);
    evq.delete();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
